// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared source codes, register-zero address and arbiter state type
package regfile_write_arbiter_pkg;
  localparam logic SRC_MEM = 1'b0;
  localparam logic SRC_EX = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic {PRIO_MEM, PRIO_EX} state_t;
endpackage

// File: rtl/regfile_write_arbiter_starvation_counter.sv
// starvation_counter: saturating wait counter, hit flags when the next count reaches MAX_WAIT
module starvation_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0] cnt, cnt_next;
  always_comb cnt_next = clr ? '0 : (inc && cnt != MAX) ? cnt + CNT_W'(1) : cnt;
  assign hit = cnt_next == MAX;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_next;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between MEM and EX writeback
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        ex_valid,
  input  logic [4:0]  ex_addr,
  input  logic [31:0] ex_data,
  output logic        ex_ready,
  output logic        reg_write,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        wb_src,
  output logic        ex_forced
);
  state_t state;
  logic same_addr, grant_mem, hit;
  logic [4:0] win_addr;
  // MEM is the older instruction, so it always wins a same-address clash
  assign same_addr = mem_valid && ex_valid && mem_addr == ex_addr;
  assign grant_mem = mem_valid && (!ex_valid || same_addr || state == PRIO_MEM);
  assign mem_ready = RST_N && grant_mem;
  assign ex_ready = RST_N && ex_valid && !grant_mem;
  assign ex_forced = state == PRIO_EX;
  assign win_addr = ex_ready ? ex_addr : mem_addr;
  starvation_counter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_cnt (
    .clk(CLK),
    .rst_n(RST_N),
    .inc(ex_valid && !ex_ready),
    .clr(!ex_valid || ex_ready),
    .hit(hit)
  );
  always_ff @(posedge CLK)
    if (!RST_N) state <= PRIO_MEM;
    else if (state == PRIO_MEM) state <= hit ? PRIO_EX : PRIO_MEM;
    else state <= (ex_ready || !ex_valid) ? PRIO_MEM : PRIO_EX;
  always_ff @(posedge CLK)
    if (!RST_N) begin
      reg_write <= 1'b0;
      A3 <= '0;
      WD3 <= '0;
      wb_src <= SRC_MEM;
    end else if (mem_ready || ex_ready) begin
      reg_write <= win_addr != REG_ZERO;
      A3 <= win_addr;
      WD3 <= ex_ready ? ex_data : mem_data;
      wb_src <= ex_ready ? SRC_EX : SRC_MEM;
    end else reg_write <= 1'b0;
endmodule
